traffic_lamp_monitor: RTL
=========================

TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter YELLOW_CYCLES, 3: exact number of cycles a street SHALL hold yellow.
REQ-002 Parameter MIN_GREEN, 5: minimum number of cycles a street SHALL hold green.
REQ-003 Parameter CNT_W, 16: width of the dwell and cycle counters.
REQ-004 clk  in  1  sole clock; every register SHALL be rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-high reset (1 = reset).
REQ-006 street_a  in  3  street A lamp; 100 = red, 010 = yellow, 001 = green.
REQ-007 street_a_pri_lamp  in  1  street A priority lamp.
REQ-008 street_b  in  3  street B lamp, same encoding as street_a.
REQ-009 street_b_pri_lamp  in  1  street B priority lamp.
REQ-010 clr  in  1  synchronous clear of the error flags, the capture and both trackers.
REQ-011 err_flags  out  5  sticky flags: [0] conflict, [1] encoding, [2] sequence, [3] timing, [4] priority.
REQ-012 err_any  out  1  OR of err_flags.
REQ-013 err_code  out  3  code of the first error: 0 = none, 1 to 5 = flag bit index + 1.
REQ-014 err_cycle  out  CNT_W  cycle-counter value at the first error.

Function
REQ-015 Lamp inputs SHALL be registered in one sample stage; the checks SHALL use the sampled values only.
REQ-016 An error present in the sample taken at edge k SHALL set its flag at edge k+1.
REQ-017 Each street SHALL run a tracker state machine with states UNKNOWN, RED, GREEN and YELLOW.
REQ-018 From UNKNOWN, any legal encoding SHALL be accepted, and the tracker SHALL enter the matching state.
REQ-019 Legal transitions: RED->GREEN, GREEN->YELLOW and YELLOW->RED; holding the same state is legal.
REQ-020 Any other transition SHALL set the sequence flag, and the tracker SHALL still adopt the new state.
REQ-021 A non-one-hot lamp value SHALL set the encoding flag; the tracker SHALL hold its state and its dwell counter.
REQ-022 The dwell counter SHALL reset to 1 on each state change, increment every cycle and saturate at all-ones.
REQ-023 Leaving YELLOW with dwell != YELLOW_CYCLES SHALL set the timing flag.
REQ-024 Leaving GREEN with dwell < MIN_GREEN SHALL set the timing flag.
REQ-025 Both streets non-red in the same sample SHALL set the conflict flag.
REQ-026 The priority flag SHALL be set when a priority lamp is on while its street is not green, or when both priority lamps are on.
REQ-027 The cycle counter SHALL be free-running and wrap at all-ones; clr SHALL NOT affect it.
REQ-028 err_code and err_cycle SHALL latch only when err_code = 0.
REQ-029 For simultaneous errors, err_code SHALL take the highest-priority one: conflict > encoding > sequence > timing > priority.
REQ-030 Simultaneous errors SHALL all set their own flags.
REQ-031 An error in the same cycle as clr SHALL be discarded, so clr wins.
REQ-032 After clr, both trackers SHALL be in UNKNOWN.

Reset
REQ-033 When rst_n = 1, the following SHALL be zero immediately: err_flags, err_any, err_code, err_cycle, the cycle counter, the dwell counters and the sampled lamps.
REQ-034 When rst_n = 1, both trackers SHALL be in UNKNOWN immediately.
REQ-035 Reset asserted mid-sequence SHALL discard all history; no error SHALL be raised on the first sample after release.

Structure
REQ-036 A package traffic_lamp_pkg SHALL hold the lamp encodings, the tracker state type and the err_code constants.
REQ-037 Sub-module lamp_street_tracker (state machine + dwell counter + sequence/timing/encoding checks) SHALL be instantiated once per street.

Verification
REQ-038 Legal cycle: A green 5, yellow 3, red, while B red, then B green 5, yellow 3 -> err_flags = 0 and err_code = 0 throughout.
REQ-039 Conflict: A = 001 and B = 010 sampled in cycle 40 -> err_flags = 00001, err_code = 1, err_cycle = 40 one cycle later.
REQ-040 Short yellow: A yellow 2 cycles, then red -> timing flag set; err_code = 4.
REQ-041 Simultaneous: A jumps GREEN->RED with B = 011 in the same sample -> encoding and sequence flags both set; err_code = 2.
REQ-042 Priority: street_b_pri_lamp = 1 while B = 100 -> err_flags[4] = 1. Then clr -> all flags 0, err_code = 0, cycle counter still running.
REQ-043 Reset: rst_n pulses mid-yellow -> all outputs 0 at once; a resume on green after release raises no error.

Source files
------------

// File: rtl/traffic_lamp_pkg.sv
// Shared lamp encodings, tracker state type and error-code constants for the
// traffic lamp monitor.
package traffic_lamp_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    TRK_UNKNOWN = 2'd0,
    TRK_RED     = 2'd1,
    TRK_GREEN   = 2'd2,
    TRK_YELLOW  = 2'd3
  } trk_state_e;

  localparam int ERR_W        = 5;
  localparam int BIT_CONFLICT = 0;
  localparam int BIT_ENCODING = 1;
  localparam int BIT_SEQUENCE = 2;
  localparam int BIT_TIMING   = 3;
  localparam int BIT_PRIORITY = 4;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_ENCODING = 3'd2;
  localparam logic [2:0] CODE_SEQUENCE = 3'd3;
  localparam logic [2:0] CODE_TIMING   = 3'd4;
  localparam logic [2:0] CODE_PRIORITY = 3'd5;

  // Lower flag index means higher priority.
  function automatic logic [2:0] first_err_code(input logic [ERR_W-1:0] errs);
    if      (errs[BIT_CONFLICT]) first_err_code = CODE_CONFLICT;
    else if (errs[BIT_ENCODING]) first_err_code = CODE_ENCODING;
    else if (errs[BIT_SEQUENCE]) first_err_code = CODE_SEQUENCE;
    else if (errs[BIT_TIMING])   first_err_code = CODE_TIMING;
    else if (errs[BIT_PRIORITY]) first_err_code = CODE_PRIORITY;
    else                         first_err_code = CODE_NONE;
  endfunction

endpackage

// File: rtl/lamp_street_tracker.sv
// Per-street lamp tracker: follows the sampled lamp colour, counts dwell cycles
// and flags encoding, sequence and dwell-timing violations.
//
//   state       | meaning
//   TRK_UNKNOWN | no history (after reset/clr); any legal colour is accepted
//   TRK_RED     | street showing red
//   TRK_GREEN   | street showing green
//   TRK_YELLOW  | street showing yellow
module lamp_street_tracker
  import traffic_lamp_pkg::*;
#(
  parameter int YELLOW_CYCLES = 3,
  parameter int MIN_GREEN     = 5,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       vld_i,
  input  logic [2:0] lamp_i,
  output logic       err_enc_o,
  output logic       err_seq_o,
  output logic       err_tim_o
);

  trk_state_e       state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  trk_state_e       lamp_st;
  logic             lamp_legal;

  function automatic logic step_ok(input trk_state_e from, input trk_state_e to);
    step_ok = (from == TRK_RED    && to == TRK_GREEN)  ||
              (from == TRK_GREEN  && to == TRK_YELLOW) ||
              (from == TRK_YELLOW && to == TRK_RED);
  endfunction

  always_comb begin
    lamp_st    = TRK_UNKNOWN;
    lamp_legal = 1'b1;
    unique case (lamp_i)
      LAMP_RED:    lamp_st = TRK_RED;
      LAMP_GREEN:  lamp_st = TRK_GREEN;
      LAMP_YELLOW: lamp_st = TRK_YELLOW;
      default:     lamp_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    err_enc_o = 1'b0;
    err_seq_o = 1'b0;
    err_tim_o = 1'b0;
    if (clr_i) begin
      state_d = TRK_UNKNOWN;
      dwell_d = '0;
    end else if (vld_i) begin
      if (!lamp_legal) begin
        err_enc_o = 1'b1;
      end else if (lamp_st != state_q) begin
        state_d = lamp_st;
        dwell_d = CNT_W'(1);
        if (state_q != TRK_UNKNOWN) begin
          err_seq_o = !step_ok(state_q, lamp_st);
          if (state_q == TRK_YELLOW && dwell_q != CNT_W'(YELLOW_CYCLES)) err_tim_o = 1'b1;
          if (state_q == TRK_GREEN  && dwell_q <  CNT_W'(MIN_GREEN))     err_tim_o = 1'b1;
        end
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= TRK_UNKNOWN;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Traffic lamp monitor top: samples both streets, runs a tracker per street and
// keeps sticky error flags plus a capture of the first error.
module traffic_lamp_monitor
  import traffic_lamp_pkg::*;
#(
  parameter int YELLOW_CYCLES = 3,
  parameter int MIN_GREEN     = 5,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       street_a,
  input  logic             street_a_pri_lamp,
  input  logic [2:0]       street_b,
  input  logic             street_b_pri_lamp,
  input  logic             clr,
  output logic [4:0]       err_flags,
  output logic             err_any,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_cycle
);

  logic [2:0]       a_q, b_q;
  logic             pa_q, pb_q;
  logic             vld_q;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [4:0]       flags_q, flags_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] ecyc_q, ecyc_d;
  logic [4:0]       new_err;
  logic             enc_a, seq_a, tim_a;
  logic             enc_b, seq_b, tim_b;
  logic             act_a, act_b;

  lamp_street_tracker #(
    .YELLOW_CYCLES (YELLOW_CYCLES),
    .MIN_GREEN     (MIN_GREEN),
    .CNT_W         (CNT_W)
  ) u_trk_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .vld_i     (vld_q),
    .lamp_i    (a_q),
    .err_enc_o (enc_a),
    .err_seq_o (seq_a),
    .err_tim_o (tim_a)
  );

  lamp_street_tracker #(
    .YELLOW_CYCLES (YELLOW_CYCLES),
    .MIN_GREEN     (MIN_GREEN),
    .CNT_W         (CNT_W)
  ) u_trk_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .vld_i     (vld_q),
    .lamp_i    (b_q),
    .err_enc_o (enc_b),
    .err_seq_o (seq_b),
    .err_tim_o (tim_b)
  );

  // A street counts as showing traffic only with a legal green or yellow.
  assign act_a = (a_q == LAMP_GREEN) || (a_q == LAMP_YELLOW);
  assign act_b = (b_q == LAMP_GREEN) || (b_q == LAMP_YELLOW);

  always_comb begin
    new_err               = '0;
    new_err[BIT_CONFLICT] = vld_q && act_a && act_b;
    new_err[BIT_ENCODING] = enc_a || enc_b;
    new_err[BIT_SEQUENCE] = seq_a || seq_b;
    new_err[BIT_TIMING]   = tim_a || tim_b;
    new_err[BIT_PRIORITY] = vld_q && ((pa_q && a_q != LAMP_GREEN) ||
                                      (pb_q && b_q != LAMP_GREEN) ||
                                      (pa_q && pb_q));
  end

  always_comb begin
    cyc_d   = cyc_q + CNT_W'(1);
    flags_d = flags_q;
    code_d  = code_q;
    ecyc_d  = ecyc_q;
    if (clr) begin
      flags_d = '0;
      code_d  = CODE_NONE;
      ecyc_d  = '0;
    end else begin
      flags_d = flags_q | new_err;
      if (code_q == CODE_NONE && new_err != '0) begin
        code_d = first_err_code(new_err);
        ecyc_d = cyc_q;
      end
    end
  end

  // vld_q masks the reset-value sample so the first real sample is the first checked.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      vld_q   <= 1'b0;
      cyc_q   <= '0;
      flags_q <= '0;
      code_q  <= CODE_NONE;
      ecyc_q  <= '0;
    end else begin
      a_q     <= street_a;
      b_q     <= street_b;
      pa_q    <= street_a_pri_lamp;
      pb_q    <= street_b_pri_lamp;
      vld_q   <= 1'b1;
      cyc_q   <= cyc_d;
      flags_q <= flags_d;
      code_q  <= code_d;
      ecyc_q  <= ecyc_d;
    end
  end

  assign err_flags = flags_q;
  assign err_any   = |flags_q;
  assign err_code  = code_q;
  assign err_cycle = ecyc_q;

endmodule
